vectored_int_ctrl: RTL and testbench



---
 rtl/vectored_int_pkg.sv | 22 ++
 rtl/int_prio_enc.sv | 47 ++++
 rtl/vectored_int_ctrl.sv | 120 ++++++++++++
 tb/tb_vectored_int_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vectored_int_pkg.sv
// Shared state type, default vector constants and one-hot helper for vectored_int_ctrl.
package vectored_int_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int          MAX_SRC       = 32;
  localparam logic [31:0] DEF_VEC_BASE  = 32'hFFFF_FFFC;
  localparam int          DEF_VEC_SHIFT = 0;

  // Indices at or beyond num_src produce an all-zero vector.
  function automatic logic [MAX_SRC-1:0] onehot(input logic [4:0] idx, input int num_src);
    logic [MAX_SRC-1:0] vec;
    vec = '0;
    if (int'(idx) < num_src) vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Combinational interrupt priority encoder: fixed highest-index-wins, or a
// rotating search that starts at 'start' and wraps modulo NUM_SRC.
module int_prio_enc #(
  parameter int NUM_SRC     = 4,
  parameter bit ROUND_ROBIN = 1'b0,
  parameter int IDX_W       = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  assign valid = |req;

  generate
    if (ROUND_ROBIN) begin : g_rr
      // First set bit found walking upward from start wins.
      always_comb begin
        int   pos;
        logic found;
        pos   = 0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
          pos = int'(start) + i;
          if (pos >= NUM_SRC) pos = pos - NUM_SRC;
          if (!found && req[IDX_W'(pos)]) begin
            idx   = IDX_W'(pos);
            found = 1'b1;
          end
        end
      end
    end else begin : g_fixed
      logic unused_start;
      assign unused_start = ^start;

      always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
          if (req[i]) idx = IDX_W'(i);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/vectored_int_ctrl.sv
// Clocked vectored interrupt controller: latches done edges, masks, and runs a
// req/ack handshake. Define VECTORED_INT_RR_EN for round-robin priority.
module vectored_int_ctrl
  import vectored_int_pkg::*;
#(
  parameter int                NUM_SRC   = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE  = ADDR_W'(DEF_VEC_BASE),
  parameter int                VEC_SHIFT = DEF_VEC_SHIFT,
  parameter int                IDX_W     = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] done,
  input  logic [NUM_SRC-1:0] int_mask,
  output logic               int_req,
  input  logic               int_ack,
  output logic [ADDR_W-1:0]  int_addr,
  output logic [IDX_W-1:0]   int_id,
  output logic [NUM_SRC-1:0] pending
);

  state_t             state;
  logic [NUM_SRC-1:0] done_q;
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] clr_vec;
  logic [NUM_SRC-1:0] eligible;
  logic               armed;
  logic               ack_take;
  logic               enc_valid;
  logic [IDX_W-1:0]   enc_idx;
  logic [IDX_W-1:0]   search_start;

  function automatic logic [ADDR_W-1:0] vec_addr(input logic [IDX_W-1:0] idx);
    return VEC_BASE | (ADDR_W'(idx) << VEC_SHIFT);
  endfunction

  // Edges are only armed once done_q has sampled the lines after reset, so a
  // level already high when reset releases never counts as a new completion.
  assign set_vec  = armed ? (done & ~done_q) : '0;
  assign ack_take = (state == REQ) && int_ack;
  assign clr_vec  = ack_take ? NUM_SRC'(onehot(5'(int_id), NUM_SRC)) : '0;
  assign eligible = pending & int_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q  <= '0;
      armed   <= 1'b0;
      pending <= '0;
    end else begin
      done_q  <= done;
      armed   <= 1'b1;
      pending <= (pending & ~clr_vec) | set_vec;
    end
  end

`ifdef VECTORED_INT_RR_EN
  localparam bit USE_RR = 1'b1;
  logic [IDX_W-1:0] last_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ptr <= '0;
    end else if (ack_take) begin
      last_ptr <= int_id;
    end
  end

  assign search_start = (last_ptr == IDX_W'(NUM_SRC - 1)) ? '0 : last_ptr + IDX_W'(1);
`else
  localparam bit USE_RR = 1'b0;
  assign search_start = '0;
`endif

  int_prio_enc #(
    .NUM_SRC     (NUM_SRC),
    .ROUND_ROBIN (USE_RR),
    .IDX_W       (IDX_W)
  ) u_prio_enc (
    .req   (eligible),
    .start (search_start),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  // Vector and id are captured once in IDLE and held through REQ and ACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      int_req  <= 1'b0;
      int_id   <= '0;
      int_addr <= VEC_BASE;
    end else begin
      case (state)
        IDLE: begin
          if (enc_valid) begin
            int_id   <= enc_idx;
            int_addr <= vec_addr(enc_idx);
            int_req  <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (int_ack) begin
            int_req <= 1'b0;
            state   <= ACK;
          end
        end
        ACK: begin
          if (!int_ack) state <= IDLE;
        end
        default: begin
          int_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vectored_int_ctrl.sv
// Scoreboard bench for vectored_int_ctrl: directed stimulus pushes expected
// vectors, a negedge monitor pops them on each new int_req.
module tb_vectored_int_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  done;
  logic [3:0]  int_mask;
  logic        int_req;
  logic        int_ack;
  logic [31:0] int_addr;
  logic [1:0]  int_id;
  logic [3:0]  pending;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];

  vectored_int_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .done     (done),
    .int_mask (int_mask),
    .int_req  (int_req),
    .int_ack  (int_ack),
    .int_addr (int_addr),
    .int_id   (int_id),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] done_v, input logic [3:0] mask_v);
    done     = done_v;
    int_mask = mask_v;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expectReq(input logic [1:0] id, input logic [31:0] addr);
    exp_t e;
    e.id   = id;
    e.addr = addr;
    exp_q.push_back(e);
  endtask

  task automatic waitReq(input string name);
    int cnt;
    cnt = 0;
    while (!int_req && cnt < 20) begin
      step(1);
      cnt++;
    end
    checkOutput(name, 32'(int_req), 32'd1);
  endtask

  task automatic ackCycle();
    int_ack = 1'b1;
    step(1);
    checkOutput("req_drop", 32'(int_req), 32'd0);
    int_ack = 1'b0;
    step(1);
  endtask

  // Monitor: every rising int_req must match the oldest expected vector.
  initial begin
    logic req_prev;
    exp_t e;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        req_prev = 1'b0;
      end else begin
        if (int_req && !req_prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_req: got id %0d addr %0h, expected no request", int_id, int_addr);
          end else begin
            e = exp_q.pop_front();
            checkOutput("req_id", 32'(int_id), 32'(e.id));
            checkOutput("req_addr", int_addr, e.addr);
          end
        end
        req_prev = int_req;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n   = 1'b1;
    done    = '0;
    int_mask = '0;
    int_ack = 1'b0;
    #1 rst_n = 1'b0;
    applyStimulus(4'hF, 4'hF);
    step(3);
    checkOutput("rst_req", 32'(int_req), 32'd0);
    checkOutput("rst_addr", int_addr, 32'hFFFF_FFFC);
    checkOutput("rst_pending", 32'(pending), 32'h0);
    checkOutput("rst_id", 32'(int_id), 32'd0);
    rst_n = 1'b1;
    step(4);
    checkOutput("held_done_req", 32'(int_req), 32'd0);
    checkOutput("held_done_pending", 32'(pending), 32'h0);

    $display("[TB] single source");
    applyStimulus(4'h0, 4'hF);
    step(2);
    expectReq(2'd2, 32'hFFFF_FFFE);
    applyStimulus(4'b0100, 4'hF);
    step(1);
    checkOutput("single_pending_set", 32'(pending), 32'h4);
    checkOutput("single_req_early", 32'(int_req), 32'd0);
    step(1);
    checkOutput("single_req_latency", 32'(int_req), 32'd1);
    ackCycle();
    checkOutput("single_pending_clr", 32'(pending), 32'h0);
    applyStimulus(4'h0, 4'hF);
    step(1);

    $display("[TB] priority and freeze");
    expectReq(2'd3, 32'hFFFF_FFFF);
    expectReq(2'd0, 32'hFFFF_FFFC);
    applyStimulus(4'b1001, 4'hF);
    waitReq("prio_hi_wait");
    ackCycle();
    waitReq("prio_lo_wait");
    applyStimulus(4'b0001, 4'hF);
    step(1);
    applyStimulus(4'b1001, 4'hF);
    step(2);
    checkOutput("freeze_addr", int_addr, 32'hFFFF_FFFC);
    checkOutput("freeze_id", 32'(int_id), 32'd0);
    checkOutput("freeze_pending", 32'(pending), 32'h9);
    checkOutput("freeze_req", 32'(int_req), 32'd1);
    expectReq(2'd3, 32'hFFFF_FFFF);
    ackCycle();
    waitReq("rearrive_wait");
    ackCycle();
    checkOutput("prio_pending_clr", 32'(pending), 32'h0);
    applyStimulus(4'h0, 4'hF);
    step(1);

    $display("[TB] mask");
    applyStimulus(4'b0010, 4'b1101);
    step(3);
    checkOutput("mask_req", 32'(int_req), 32'd0);
    checkOutput("mask_pending", 32'(pending), 32'h2);
    expectReq(2'd1, 32'hFFFF_FFFD);
    applyStimulus(4'b0010, 4'hF);
    waitReq("mask_wait");
    ackCycle();
    checkOutput("mask_pending_clr", 32'(pending), 32'h0);
    applyStimulus(4'h0, 4'hF);
    step(1);

    $display("[TB] set/clear collision");
    expectReq(2'd1, 32'hFFFF_FFFD);
    applyStimulus(4'b0010, 4'hF);
    waitReq("coll_wait");
    applyStimulus(4'b0000, 4'hF);
    step(1);
    expectReq(2'd1, 32'hFFFF_FFFD);
    applyStimulus(4'b0010, 4'hF);
    int_ack = 1'b1;
    step(1);
    checkOutput("coll_pending", 32'(pending), 32'h2);
    checkOutput("coll_req_drop", 32'(int_req), 32'd0);
    int_ack = 1'b0;
    waitReq("coll_again_wait");
    ackCycle();
    checkOutput("coll_pending_clr", 32'(pending), 32'h0);
    applyStimulus(4'h0, 4'hF);
    step(1);

    $display("[TB] ack while idle");
    applyStimulus(4'b0001, 4'b0000);
    step(2);
    checkOutput("idle_pending", 32'(pending), 32'h1);
    int_ack = 1'b1;
    step(2);
    checkOutput("idle_ack_pending", 32'(pending), 32'h1);
    checkOutput("idle_ack_req", 32'(int_req), 32'd0);
    int_ack = 1'b0;
    step(1);
    expectReq(2'd0, 32'hFFFF_FFFC);
    applyStimulus(4'b0001, 4'hF);
    waitReq("idle_unmask_wait");
    ackCycle();
    applyStimulus(4'h0, 4'hF);
    step(1);

    $display("[TB] async reset during request");
    expectReq(2'd2, 32'hFFFF_FFFE);
    applyStimulus(4'b0100, 4'hF);
    waitReq("areset_wait");
    #5;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_req", 32'(int_req), 32'd0);
    checkOutput("areset_addr", int_addr, 32'hFFFF_FFFC);
    checkOutput("areset_id", 32'(int_id), 32'd0);
    checkOutput("areset_pending", 32'(pending), 32'h0);
    step(1);
    rst_n = 1'b1;
    step(3);
    checkOutput("areset_held_req", 32'(int_req), 32'd0);
    checkOutput("areset_held_pending", 32'(pending), 32'h0);
    applyStimulus(4'h0, 4'hF);
    step(1);

    $display("[TB] service order with all sources pending");
`ifdef VECTORED_INT_RR_EN
    expectReq(2'd1, 32'hFFFF_FFFD);
    expectReq(2'd2, 32'hFFFF_FFFE);
    expectReq(2'd3, 32'hFFFF_FFFF);
    expectReq(2'd0, 32'hFFFF_FFFC);
`else
    expectReq(2'd3, 32'hFFFF_FFFF);
    expectReq(2'd2, 32'hFFFF_FFFE);
    expectReq(2'd1, 32'hFFFF_FFFD);
    expectReq(2'd0, 32'hFFFF_FFFC);
`endif
    applyStimulus(4'hF, 4'hF);
    for (int i = 0; i < 4; i++) begin
      waitReq("order_wait");
      ackCycle();
    end
    checkOutput("order_pending", 32'(pending), 32'h0);

    step(3);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
